pattern_stream_tx: RTL and testbench
====================================

# pattern_stream_tx

Serial frame transmitter that drives the single-bit `x` stream consumed by the sequence/pattern detector blocks. A parallel word is accepted over a ready/load handshake. The block then emits a fixed sync pattern followed by the word, MSB first, one bit per `clk` cycle, and finishes with a run of idle gap cycles. It sits upstream of the detector as the stimulus and transmit side of the same one-bit interface, and it can also serve as a reusable stimulus source in benches.

## Interface
- `DATA_W`, 32: payload width in bits; must be at least 1.
- `SYNC_W`, 4: sync pattern width in bits; must be at least 1.
- `SYNC_PAT`, 4'b1011: sync pattern, sent MSB first.
- `GAP`, 2: number of idle cycles after each frame; may be 0.

- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `load`, in, 1: request to start a frame; accepted only on an edge where `ready`=1.
- `data_in`, in, DATA_W: payload word; sampled on the accepting edge.
- `ready`, out, 1: block is idle and will accept `load`.
- `x`, out, 1: serial output bit.
- `x_valid`, out, 1: `x` carries a frame bit (sync or payload).
- `frame_done`, out, 1: one-cycle pulse coincident with the last payload bit.

## Operation
- All outputs are registered.
- Reset (`rst_n`=0 at an edge) forces the following, regardless of state, including in the middle of a frame:
  - state = IDLE;
  - `ready`=1, `x`=0, `x_valid`=0, `frame_done`=0;
  - shift register and counters cleared.
- FSM states:
  - IDLE: `ready`=1, `x`=0, `x_valid`=0. `load`=1 → capture `data_in` into the shift register, go to SYNC.
  - SYNC: `x` = `SYNC_PAT[SYNC_W-1-k]` for k = 0..SYNC_W-1, `x_valid`=1, `ready`=0. After SYNC_W bits → DATA.
  - DATA: `x` = the captured word, bits DATA_W-1 down to 0, `x_valid`=1. On the last bit `frame_done`=1. After DATA_W bits → GAP, or → IDLE if GAP=0.
  - GAP: `x`=0, `x_valid`=0, `ready`=0 for GAP cycles, then → IDLE.
- `load` while `ready`=0 is ignored, not queued. `data_in` is don't-care except on the accepting edge.
- The payload is held internally. Changing `data_in` during a frame has no effect.
- Bit counter width: clog2(max(SYNC_W, DATA_W, GAP)+1). The counter never wraps past its terminal count.

## Timing
- Let E0 be the accepting edge (`load`=1 and `ready`=1).
- After E0: `ready`=0, `x_valid`=1, and `x` = sync bit 0. Latency from accept to first bit is one edge.
- Cycle n after E0 (n = 1..SYNC_W+DATA_W) holds frame bit n−1. The cycles are contiguous with no bubbles.
- `frame_done`=1 only during cycle SYNC_W+DATA_W (36 with defaults).
- After edge E0+SYNC_W+DATA_W: `x_valid`=0 and `x`=0.
- `ready` returns to 1 after edge E0+SYNC_W+DATA_W+GAP (38 with defaults). A `load` on that same edge is accepted, which gives a frame period of SYNC_W+DATA_W+GAP+1 cycles back-to-back.
- GAP=0: the cycle after the last bit is IDLE with `ready`=1. One bubble cycle with `x_valid`=0 always separates frames.
- A reset edge during any frame cycle takes effect on that edge. The next cycle shows the IDLE outputs listed above, and a `load` in that next cycle is accepted normally.
- `load` held high continuously starts a new frame at every opportunity.

## Test plan
- Defaults. After reset, `load`=1 for one cycle with `data_in`=32'h69D1BC2E → `x` over cycles 1..36 = 1011 then 0110 1001 1101 0001 1011 1100 0010 1110; `x_valid`=1 throughout; `frame_done` high only in cycle 36; `ready`=1 again after edge 38.
- Held `load`=1 with words 32'hFFFFFFFF then 32'h00000000 → two frames spaced 39 cycles apart; second payload all zeros; `load` ignored while `ready`=0.
- `data_in` changed every cycle during a frame with `data_in`=32'hA5A5A5A5 at accept → transmitted payload is A5A5A5A5 exactly.
- `rst_n`=0 for one edge at cycle 20 of a frame → next cycle `x`=0, `x_valid`=0, `ready`=1, `frame_done`=0; a new `load` immediately after yields a complete, correct frame.
- Parameters DATA_W=8, SYNC_W=3, SYNC_PAT=3'b110, GAP=0 with `data_in`=8'h81 → `x` = 110 10000001 over cycles 1..11; `frame_done` in cycle 11; `ready`=1 in cycle 12.
- Loopback into the sequence detector with its target pattern embedded in the payload → detector `y` asserts at the expected bit position and does not fire falsely during the sync/gap boundary.

Source files
------------

// File: rtl/pattern_stream_tx_if.sv
// Frame-transmitter bus: parallel word in over a ready/load handshake,
// serial bit stream out with a validity flag and an end-of-frame pulse.
interface pattern_stream_tx_if #(
  parameter int DATA_W = 32
);
  // Handshake: load is taken on a rising edge only while ready is high and is
  // dropped otherwise; data_in matters only on that edge. x is meaningful only
  // while x_valid is high, and frame_done marks the final payload bit.
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              x;
  logic              x_valid;
  logic              frame_done;

  modport master (
    input  load,
    input  data_in,
    output ready,
    output x,
    output x_valid,
    output frame_done
  );

  modport slave (
    output load,
    output data_in,
    input  ready,
    input  x,
    input  x_valid,
    input  frame_done
  );
endinterface

// File: rtl/pattern_stream_tx.sv
// Serial frame transmitter: sync pattern, then the captured word MSB first,
// then GAP idle cycles. All outputs come straight from flops.
module pattern_stream_tx #(
  parameter int                DATA_W   = 32,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  parameter int                GAP      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pattern_stream_tx_if.master  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int FRAME_W = SYNC_W + DATA_W;
  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_ALL = (MAX_SD > GAP) ? MAX_SD : GAP;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // cnt_q holds how many cycles of the current state have already been shown,
  // so each state leaves when cnt_q reaches its own length.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.load) begin
          // Sync and payload share one shift register; first sync bit leaves now.
          state_d   = ST_SYNC;
          shreg_d   = {SYNC_PAT, bus.data_in} << 1;
          x_d       = SYNC_PAT[SYNC_W-1];
          x_valid_d = 1'b1;
          ready_d   = 1'b0;
          cnt_d     = CNT_ONE;
        end
      end
      ST_SYNC: begin
        x_d       = shreg_q[FRAME_W-1];
        shreg_d   = shreg_q << 1;
        x_valid_d = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_DATA;
          cnt_d   = CNT_ONE;
          done_d  = (DATA_W == 1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CNT_ONE;
          end
        end else begin
          x_d       = shreg_q[FRAME_W-1];
          shreg_d   = shreg_q << 1;
          x_valid_d = 1'b1;
          done_d    = (cnt_q == DATA_PEN);
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.ready      = ready_q;
  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Bench for pattern_stream_tx: default instance plus a small GAP=0 instance,
// checked every cycle against a frame-timeline model and literal frames.
module tb_pattern_stream_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pattern_stream_tx_if #(.DATA_W(32)) bus();
  pattern_stream_tx_if #(.DATA_W(8))  bus_s();
  logic [1:0] dbg_m, dbg_s;

  pattern_stream_tx u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_m)
  );

  pattern_stream_tx #(
    .DATA_W   (8),
    .SYNC_W   (3),
    .SYNC_PAT (3'b110),
    .GAP      (0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_s),
    .dbg_state_o (dbg_s)
  );

  localparam int FL_M = 36, G_M = 2;
  localparam int FL_S = 11, G_S = 0;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: k = cycles since the accepting edge (0 = idle), plus the frame bits.
  int          k_m = 0, k_s = 0;
  logic [63:0] fr_m = '0, fr_s = '0;

  logic [127:0] cap_m, cap_s;
  int           ncap_m, ncap_s;

  function automatic int model_next(int k, logic rst, logic ld, int fl, int g);
    if (!rst) return 0;
    if (k == 0) return ld ? 1 : 0;
    if (k >= fl + g) return 0;
    return k + 1;
  endfunction

  // Returns {ready, x, x_valid, frame_done} for timeline position k.
  function automatic logic [3:0] model_out(int k, logic [63:0] fr, int fl);
    logic [3:0] o;
    o = 4'b0000;
    if (k == 0) o[3] = 1'b1;
    else if (k <= fl) begin
      o[2] = fr[fl-k];
      o[1] = 1'b1;
      o[0] = (k == fl);
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // One clock: advance the model from the inputs the edge will sample,
  // then compare both DUTs after the edge and collect valid bits.
  task automatic step();
    int kn_m, kn_s;
    kn_m = model_next(k_m, rst_n, bus.load, FL_M, G_M);
    kn_s = model_next(k_s, rst_n, bus_s.load, FL_S, G_S);
    if (kn_m == 1) fr_m = {28'd0, 4'b1011, bus.data_in};
    if (kn_s == 1) fr_s = {53'd0, 3'b110, bus_s.data_in};
    @(posedge clk);
    #2;
    k_m = kn_m;
    k_s = kn_s;
    if (chk_en) begin
      check("cyc_main", {124'd0, bus.ready, bus.x, bus.x_valid, bus.frame_done},
            {124'd0, model_out(k_m, fr_m, FL_M)});
      check("cyc_small", {124'd0, bus_s.ready, bus_s.x, bus_s.x_valid, bus_s.frame_done},
            {124'd0, model_out(k_s, fr_s, FL_S)});
      if (bus.x_valid) begin
        cap_m = {cap_m[126:0], bus.x};
        ncap_m++;
      end
      if (bus_s.x_valid) begin
        cap_s = {cap_s[126:0], bus_s.x};
        ncap_s++;
      end
    end
  endtask

  task automatic clear_cap();
    cap_m = '0; ncap_m = 0;
    cap_s = '0; ncap_s = 0;
  endtask

  initial begin
    int fd_k, rdy_k, rise_a, rise_b, n_rise;
    bit prev;

    rst_n = 1'b0;
    bus.load = 1'b0;   bus.data_in = '0;
    bus_s.load = 1'b0; bus_s.data_in = '0;
    clear_cap();
    step();
    chk_en = 1'b1;
    step();
    check("rst_main_outputs", {124'd0, bus.ready, bus.x, bus.x_valid, bus.frame_done}, 128'b1000);
    check("rst_small_outputs", {124'd0, bus_s.ready, bus_s.x, bus_s.x_valid, bus_s.frame_done}, 128'b1000);
    rst_n = 1'b1;
    step();

    // Default frame with a mixed payload
    clear_cap();
    bus.load = 1'b1; bus.data_in = 32'h69D1BC2E;
    step();
    bus.load = 1'b0; bus.data_in = $urandom;
    fd_k = 0; rdy_k = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.frame_done && fd_k == 0) fd_k = k;
      if (bus.ready && rdy_k == 0) rdy_k = k;
      step();
    end
    check("t1_bits", cap_m, 128'hB69D1BC2E);
    check("t1_nbits", ncap_m, 36);
    check("t1_done_cycle", fd_k, 36);
    check("t1_ready_cycle", rdy_k, 39);

    // Held load: two back-to-back frames
    clear_cap();
    bus.load = 1'b1; bus.data_in = 32'hFFFFFFFF;
    step();
    bus.data_in = 32'h00000000;
    prev = 1'b0; n_rise = 0; rise_a = 0; rise_b = 0;
    for (int k = 1; k <= 90; k++) begin
      if (bus.x_valid && !prev) begin
        if (n_rise == 0) rise_a = k;
        else if (n_rise == 1) rise_b = k;
        n_rise++;
      end
      prev = bus.x_valid;
      if (k == 77) bus.load = 1'b0;
      step();
    end
    check("t2_frame_count", n_rise, 2);
    check("t2_period", rise_b - rise_a, 39);
    check("t2_bits", cap_m, {56'd0, 36'hBFFFFFFFF, 36'hB00000000});

    // Payload held while data_in and load wander during the frame
    clear_cap();
    bus.load = 1'b1; bus.data_in = 32'hA5A5A5A5;
    step();
    for (int k = 1; k <= 40; k++) begin
      bus.data_in = $urandom;
      bus.load = (k <= 34) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    check("t3_bits", cap_m, 128'hBA5A5A5A5);
    check("t3_nbits", ncap_m, 36);

    // Reset in cycle 20 of a frame, then an immediate new frame
    bus.load = 1'b1; bus.data_in = 32'h12345678;
    step();
    bus.load = 1'b0;
    for (int k = 1; k <= 19; k++) step();
    rst_n = 1'b0;
    step();
    check("t4_after_rst", {124'd0, bus.ready, bus.x, bus.x_valid, bus.frame_done}, 128'b1000);
    rst_n = 1'b1;
    clear_cap();
    bus.load = 1'b1; bus.data_in = 32'h0F0F3C96;
    step();
    bus.load = 1'b0;
    for (int k = 1; k <= 40; k++) step();
    check("t4_bits", cap_m, 128'hB0F0F3C96);
    check("t4_nbits", ncap_m, 36);

    // Small instance: 8-bit payload, 3-bit sync, no gap
    clear_cap();
    bus_s.load = 1'b1; bus_s.data_in = 8'h81;
    step();
    bus_s.load = 1'b0;
    fd_k = 0; rdy_k = 0;
    for (int k = 1; k <= 14; k++) begin
      if (bus_s.frame_done && fd_k == 0) fd_k = k;
      if (bus_s.ready && rdy_k == 0) rdy_k = k;
      step();
    end
    check("t5_bits", cap_s, 128'h681);
    check("t5_nbits", ncap_s, 11);
    check("t5_done_cycle", fd_k, 11);
    check("t5_ready_cycle", rdy_k, 12);

    // Small instance with held load: one bubble between frames
    clear_cap();
    bus_s.load = 1'b1; bus_s.data_in = 8'h3C;
    step();
    bus_s.data_in = 8'hC3;
    prev = 1'b0; n_rise = 0; rise_a = 0; rise_b = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus_s.x_valid && !prev) begin
        if (n_rise == 0) rise_a = k;
        else if (n_rise == 1) rise_b = k;
        n_rise++;
      end
      prev = bus_s.x_valid;
      if (k == 22) bus_s.load = 1'b0;
      step();
    end
    check("t6_frame_count", n_rise, 2);
    check("t6_period", rise_b - rise_a, 12);
    check("t6_bits", cap_s, {106'd0, 3'b110, 8'h3C, 3'b110, 8'hC3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
